bcd_to_bin: RTL and testbench
=============================

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 The module SHALL have one parameter: N_DIGITS, default 3, number of packed BCD input digits.
REQ-002 The module SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port i_start, input, 1 bit: conversion request, sampled at each rising edge.
REQ-005 The module SHALL have port i_bcd, input, 12 bits: digits packed as [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-006 The module SHALL have port o_bin, output, 10 bits: binary result, 0..999.
REQ-007 The module SHALL have port o_busy, output, 1 bit: conversion in progress.
REQ-008 The module SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-009 The module SHALL have port o_err, output, 1 bit: the last request held an invalid digit (>9).

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-011 In IDLE with i_start=1 at edge E0, all three digits ≤9: load the 22-bit work register {i_bcd, 10'b0}, clear the iteration counter, clear o_err, enter SHIFT, set o_busy=1.
REQ-012 In IDLE with i_start=1 and any digit >9: stay IDLE, set o_err=1 and o_bin=0, pulse o_done for one cycle at the next edge.
REQ-013 Each SHIFT edge SHALL shift the whole work register right 1 bit, then subtract 3 from each BCD digit whose post-shift value is ≥8.
REQ-014 Exactly 10 SHIFT iterations SHALL occur (E1..E10); at E10, o_bin takes work[9:0], o_done=1, o_busy=0, state returns to IDLE.
REQ-015 o_done SHALL be high for exactly one cycle per accepted request.
REQ-016 o_bin and o_err SHALL hold their values until the next accepted request or reset.
REQ-017 i_start while in SHIFT SHALL be ignored, with no queuing.
REQ-018 i_start in the cycle in which o_done=1 (state IDLE) SHALL be accepted, allowing back-to-back conversions every 11 cycles.
REQ-019 i_bcd SHALL be sampled only at the accepting edge; later changes SHALL not affect the result.
REQ-020 Arithmetic SHALL be unsigned: 4-bit digits, 4-bit counter.
REQ-021 The subtract-3 correction SHALL never underflow, since a digit ≥8 minus 3 is always ≥5.

Reset
REQ-022 With i_rst=1 at an edge: state=IDLE, work register=0, counter=0, o_bin=0, o_busy=0, o_done=0, o_err=0.
REQ-023 Reset SHALL take precedence over i_start and over any conversion in progress; a mid-conversion reset aborts with no o_done pulse.

Structure
REQ-024 A shared package SHALL hold: BCD_DIGIT_W=4, BIN_W=10, N_ITER=10, the state enum {IDLE, SHIFT}, and the constant DIGIT_MAX=4'd9.
REQ-025 The per-shift correction SHALL be a combinational sub-module, sub_condition: 12-bit digits in/out, subtract 3 from each digit ≥8, otherwise pass through.
REQ-026 The FSM, counter and work register SHALL reside in bcd_to_bin.

Verification
REQ-027 i_bcd=12'h000, start -> o_done 10 cycles after the accept edge, o_bin=0, o_err=0.
REQ-028 i_bcd=12'h999 -> o_bin=10'd999; i_bcd=12'h255 -> o_bin=10'd255; i_bcd=12'h128 -> o_bin=10'd128.
REQ-029 i_bcd=12'h1A3, start -> o_err=1, o_bin=0, o_done pulse on the next cycle, o_busy never high.
REQ-030 Start 12'h042, pulse i_start again at E4 with i_bcd=12'h777 -> single o_done at E10, o_bin=10'd42.
REQ-031 Start 12'h500, assert i_rst at E5 -> all outputs 0 and no o_done; a subsequent start with 12'h007 -> o_bin=10'd7.
REQ-032 Back-to-back: i_start held high with 12'h321 then 12'h654 -> o_done pulses 11 cycles apart, o_bin=321 then 654.

Source files
------------

// File: rtl/bcd_to_bin_pkg.sv
// rtl/bcd_to_bin_pkg.sv - shared constants and types for the BCD-to-binary converter
package bcd_to_bin_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BIN_W       = 10;
  localparam int N_ITER      = 10;

  localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sub_condition.sv
// rtl/sub_condition.sv - per-shift digit correction: subtract 3 from every BCD digit >= 8
module sub_condition
  import bcd_to_bin_pkg::*;
#(
  parameter int N_DIGITS = 3
) (
  input  logic [N_DIGITS*BCD_DIGIT_W-1:0] digits_in,
  output logic [N_DIGITS*BCD_DIGIT_W-1:0] digits_out
);

  // A digit >= 8 minus 3 is at least 5, so the subtraction never wraps.
  always_comb begin
    digits_out = digits_in;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digits_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd8) begin
        digits_out[i*BCD_DIGIT_W +: BCD_DIGIT_W] = digits_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] - 4'd3;
      end
    end
  end

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential shift-and-subtract BCD to binary converter
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int N_DIGITS = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic [N_DIGITS*BCD_DIGIT_W-1:0] i_bcd,
  output logic [BIN_W-1:0]                o_bin,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err
);

  localparam int BCD_W  = N_DIGITS * BCD_DIGIT_W;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam logic [3:0] LAST_ITER = 4'(N_ITER - 1);

  state_t            state;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] shifted;
  logic [WORK_W-1:0] next_work;
  logic [BCD_W-1:0]  corrected;
  logic [3:0]        cnt;
  logic              bcd_ok;

  always_comb begin
    bcd_ok = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > DIGIT_MAX) begin
        bcd_ok = 1'b0;
      end
    end
  end

  // BCD digits sit above the binary field; bits fall out of the BCD side into it.
  assign shifted = work >> 1;

  sub_condition #(
    .N_DIGITS(N_DIGITS)
  ) u_sub_condition (
    .digits_in (shifted[WORK_W-1:BIN_W]),
    .digits_out(corrected)
  );

  assign next_work = {corrected, shifted[BIN_W-1:0]};

  always_ff @(posedge i_clk) begin
    o_done <= 1'b0;
    if (i_rst) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      o_bin  <= '0;
      o_busy <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            if (bcd_ok) begin
              work   <= {i_bcd, {BIN_W{1'b0}}};
              cnt    <= '0;
              o_err  <= 1'b0;
              o_busy <= 1'b1;
              state  <= SHIFT;
            end else begin
              o_err  <= 1'b1;
              o_bin  <= '0;
              o_done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work <= next_work;
          cnt  <= cnt + 4'd1;
          if (cnt == LAST_ITER) begin
            o_bin  <= next_work[BIN_W-1:0];
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - scoreboard bench for bcd_to_bin
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] bcd;
  logic [9:0]  bin;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [9:0] bin;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  bcd_to_bin #(.N_DIGITS(3)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_bcd  (bcd),
    .o_bin  (bin),
    .o_busy (busy),
    .o_done (done),
    .o_err  (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic exp_t model(input logic [11:0] v, input int now);
    exp_t e;
    e.err = (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    e.bin = e.err ? 10'd0 : 10'(v[11:8] * 100 + v[7:4] * 10 + v[3:0]);
    e.cyc = now + (e.err ? 1 : 11);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bin", bin, e.bin);
        check("err", err, e.err);
        check("done_cycle", cyc, e.cyc);
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  task automatic start_req(input logic [11:0] v, input logic push);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    bcd   = v;
    e = model(v, cyc);
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, !e.err);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bcd   = 12'h000;
    repeat (2) @(negedge clk);
    check("rst_bin", bin, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    start_req(12'h000, 1'b1); wait_idle();
    start_req(12'h999, 1'b1); wait_idle();
    start_req(12'h255, 1'b1); wait_idle();
    start_req(12'h128, 1'b1); wait_idle();

    start_req(12'h1A3, 1'b1);
    check("err_busy_later", busy, 0);
    wait_idle();

    // Second request mid-conversion must be dropped; later i_bcd changes must not matter.
    start_req(12'h042, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    bcd   = 12'h777;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("hold_bin", bin, 42);

    // Reset at E5 aborts the conversion without a done pulse.
    start_req(12'h500, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_bin", bin, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    repeat (15) @(negedge clk);
    start_req(12'h007, 1'b1); wait_idle();

    // Back-to-back with start held high.
    @(negedge clk);
    begin
      exp_t e1, e2;
      e1 = model(12'h321, cyc);
      e2 = model(12'h654, cyc + 11);
      sb.push_back(e1);
      sb.push_back(e2);
    end
    start = 1'b1;
    bcd   = 12'h321;
    @(negedge clk);
    bcd = 12'h654;
    repeat (11) @(negedge clk);
    start = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, pending %0d", sb.size());
    $fatal(1);
  end

endmodule
